// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the two-port round-robin front end of the data RAM.
// Holds the default widths, the FSM state encoding and the requester ids.
package ram_port_arbiter_pkg;

    localparam int AW_DEF      = 11;
    localparam int DW_DEF      = 16;
    localparam int RAM_LAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Requester ids double as the stored last-grant value.
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/ram_port_arbiter_arb.sv
// Combinational two-way round-robin pick: a lone request wins outright,
// a tie goes to the port that was not granted last time.
module rr_arbiter2
    import ram_port_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_gnt,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            gnt = (last_gnt == PORT1) ? 2'b01 : 2'b10;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between the MEM stage (port 0) and the
// debug/loader (port 1): one transaction in flight, req/ack handshake.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int AW      = AW_DEF,
    parameter int DW      = DW_DEF,
    parameter int RAM_LAT = RAM_LAT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_wea,
    output logic [AW-1:0] mem_addra,
    output logic [DW-1:0] mem_dina,
    input  logic [DW-1:0] mem_douta,
    output logic [1:0]    fsm_state
);

    localparam int CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [CW-1:0] WAIT_INIT = CW'(RAM_LAT - 1);

    // Handshake: a requester holds reqN (with we/addr/wdata stable) until it
    // sees the one-cycle ackN; inputs are only looked at while IDLE, and a
    // req still high after ack is treated as a fresh request.

    state_t        state;
    logic          last_gnt;
    logic          win;
    logic [CW-1:0] cnt;
    logic [1:0]    gnt;

    rr_arbiter2 u_arb (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt),
        .gnt      (gnt)
    );

    assign fsm_state = state;

    // The RAM drive registers are loaded on the grant edge so that the
    // write strobe lands in the ACCESS cycle itself; they are the latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            last_gnt  <= PORT1;
            win       <= PORT0;
            cnt       <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            mem_wea   <= 1'b0;
            mem_addra <= '0;
            mem_dina  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        win       <= gnt[1];
                        last_gnt  <= gnt[1];
                        mem_wea   <= gnt[1] ? we1 : we0;
                        mem_addra <= gnt[1] ? addr1 : addr0;
                        mem_dina  <= gnt[1] ? wdata1 : wdata0;
                        busy      <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_wea <= 1'b0;
                    cnt     <= WAIT_INIT;
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        rdata <= mem_douta;
                        ack0  <= (win == PORT0);
                        ack1  <= (win == PORT1);
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM attached:
// a vector table, hand sequences for multi-cycle corners, then random traffic.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [10:0] addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, busy, mem_wea;
    logic [15:0] rdata, mem_dina, mem_douta;
    logic [10:0] mem_addra;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    logic [15:0] ram     [0:2047];
    logic [15:0] ref_mem [0:2047];
    int          last_served;

    always #5 clk = ~clk;

    ram_port_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina),
        .mem_douta(mem_douta), .fsm_state(fsm_state)
    );

    // Registered-read single-port RAM, one cycle of read latency.
    always @(posedge clk) begin
        if (mem_wea) ram[mem_addra] <= mem_dina;
        mem_douta <= ram[mem_addra];
    end

    typedef struct {
        string       name;
        logic        rst_before;
        logic        r0, w0;
        logic [10:0] a0;
        logic [15:0] d0;
        logic        r1, w1;
        logic [10:0] a1;
        logic [15:0] d1;
        int          exp_port;
        logic        chk_rd;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Spec-level arbitration rule: lone requester wins, tie goes to the
    // port that was not served most recently.
    function automatic int model_winner(input logic r0, input logic r1);
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        return (last_served == 0) ? 1 : 0;
    endfunction

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        last_served = 1;
    endtask

    // Starts at a negedge with the DUT idle, ends at a negedge with it idle.
    task automatic run_txn(input string nm,
                           input logic r0, input logic w0, input logic [10:0] a0, input logic [15:0] d0,
                           input logic r1, input logic w1, input logic [10:0] a1, input logic [15:0] d1,
                           input int ep, input logic chk_rd, input logic [15:0] erd);
        logic        ew;
        logic [10:0] ea;
        logic [15:0] ed;
        ew = (ep == 1) ? w1 : w0;
        ea = (ep == 1) ? a1 : a0;
        ed = (ep == 1) ? d1 : d0;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        // Post-grant changes must not disturb the transaction.
        req0 = 1'b0; req1 = 1'b0; we0 = ~w0; we1 = ~w1; addr0 = ~a0; addr1 = ~a1;
        wdata0 = ~d0; wdata1 = ~d1;
        check({nm, " c1 wea"}, mem_wea, ew);
        check({nm, " c1 addra"}, mem_addra, ea);
        if (ew) check({nm, " c1 dina"}, mem_dina, ed);
        check({nm, " c1 busy"}, busy, 1);
        @(negedge clk);
        check({nm, " c2 wea"}, mem_wea, 0);
        check({nm, " c2 acks"}, {ack1, ack0}, 0);
        @(negedge clk);
        check({nm, " c3 ack0"}, ack0, (ep == 0));
        check({nm, " c3 ack1"}, ack1, (ep == 1));
        if (chk_rd) check({nm, " c3 rdata"}, rdata, erd);
        if (ew) ref_mem[ea] = ed;
        last_served = ep;
        @(negedge clk);
        check({nm, " c4 acks"}, {ack1, ack0}, 0);
        check({nm, " c4 busy"}, busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r0, r1, w0, w1;
        logic [10:0] a0, a1;
        logic [15:0] d0, d1;
        int          p;

        for (int i = 0; i < 2048; i++) begin
            ram[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        last_served = 1;

        vecs[0] = '{"v0 p0 wr", 1'b0, 1'b1, 1'b1, 11'd1, 16'h0001, 1'b0, 1'b0, 11'd0, 16'h0000, 0, 1'b0, 16'h0000};
        vecs[1] = '{"v1 p0 rd", 1'b0, 1'b1, 1'b0, 11'd1, 16'h0000, 1'b0, 1'b0, 11'd0, 16'h0000, 0, 1'b1, 16'h0001};
        vecs[2] = '{"v2 tie p0", 1'b1, 1'b1, 1'b0, 11'd5, 16'h0000, 1'b1, 1'b1, 11'd5, 16'hAAAA, 0, 1'b1, 16'h0000};
        vecs[3] = '{"v3 tie p1", 1'b0, 1'b1, 1'b0, 11'd5, 16'h0000, 1'b1, 1'b1, 11'd5, 16'hAAAA, 1, 1'b0, 16'h0000};
        vecs[4] = '{"v4 reread", 1'b0, 1'b1, 1'b0, 11'd5, 16'h0000, 1'b0, 1'b0, 11'd0, 16'h0000, 0, 1'b1, 16'hAAAA};
        vecs[5] = '{"v5 p1 rd", 1'b0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b1, 1'b0, 11'd1, 16'h0000, 1, 1'b1, 16'h0001};

        // Reset held three cycles.
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst ack0", ack0, 0);
        check("rst ack1", ack1, 0);
        check("rst busy", busy, 0);
        check("rst wea", mem_wea, 0);
        check("rst rdata", rdata, 0);
        check("rst state", fsm_state, 0);
        reset = 1'b0;
        last_served = 1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].rst_before) begin
                do_reset(2);
            end
            run_txn(vecs[i].name, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
                    vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1,
                    vecs[i].exp_port, vecs[i].chk_rd, vecs[i].exp_rd);
        end

        // Both requests held for 16 cycles: alternating grants, ack every 4.
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 11'd5;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            check("s4 dual ack", ack0 & ack1, 0);
            if (k % 4 == 3) begin
                p = model_winner(1'b1, 1'b1);
                check("s4 ack0", ack0, (p == 0));
                check("s4 ack1", ack1, (p == 1));
                check("s4 rdata", rdata, ref_mem[(p == 1) ? addr1 : addr0]);
                last_served = p;
            end else begin
                check("s4 no ack", {ack1, ack0}, 0);
            end
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset during ACCESS of a port-1 read: transaction is lost.
        req1 = 1'b1; we1 = 1'b0; addr1 = 11'd1;
        @(negedge clk);
        check("s5 access busy", busy, 1);
        req1 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("s5 busy", busy, 0);
        check("s5 ack1", ack1, 0);
        check("s5 wea", mem_wea, 0);
        reset = 1'b0;
        last_served = 1;
        repeat (3) begin
            @(negedge clk);
            check("s5 no late ack", {ack1, ack0}, 0);
        end
        run_txn("s5 tie after rst", 1'b1, 1'b0, 11'd5, 16'h0, 1'b1, 1'b0, 11'd1, 16'h0,
                0, 1'b1, 16'hAAAA);

        // req0 dropped right after grant (the task drops it in cycle 1).
        run_txn("s6 wr", 1'b1, 1'b1, 11'd9, 16'h1234, 1'b0, 1'b0, 11'd0, 16'h0, 0, 1'b0, 16'h0);
        run_txn("s6 rd", 1'b1, 1'b0, 11'd9, 16'h0000, 1'b0, 1'b0, 11'd0, 16'h0, 0, 1'b1, 16'h1234);

        // Random traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            w0 = 1'($urandom_range(0, 1));
            w1 = 1'($urandom_range(0, 1));
            a0 = 11'($urandom_range(0, 7));
            a1 = 11'($urandom_range(0, 7));
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            p = model_winner(r0, r1);
            run_txn("rnd", r0, w0, a0, d0, r1, w1, a1, d1, p,
                    (p == 1) ? !w1 : !w0, ref_mem[(p == 1) ? a1 : a0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
